// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB4 requester: single-beat commands to SETUP/ACCESS transfers with wait-state timeout
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_strb,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic                  pready,
    input  logic [31:0]           prdata,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign cmd_ready = (state == IDLE);

    // Abort on the TIMEOUT_CYCLES-th low-pready cycle; a same-cycle pready wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pready && (wait_cnt == LIMIT);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        psel     <= 1'b1;
                        paddr    <= cmd_addr;
                        pwrite   <= cmd_write;
                        pwdata   <= cmd_write ? cmd_wdata : 32'd0;
                        pstrb    <= cmd_write ? cmd_strb : 4'd0;
                        wait_cnt <= '0;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? 32'd0 : prdata;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= 32'd0;
                    end else if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

    localparam int AW = 10;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_write = 1'b0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic          pready = 1'b0;
    logic [31:0]   prdata = '0;
    logic          pslverr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    apb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One command: SETUP checks, ACCESS stability checks, then response checks.
    task automatic run_cmd(input string t, input logic [AW-1:0] a, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st, input int waits,
                           input logic to_mode, input logic [31:0] prd, input logic perr,
                           input logic [31:0] exp_rd, input logic exp_err, input logic exp_to);
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        int          n_acc;
        exp_wd = wr ? wd : 32'd0;
        exp_st = wr ? st : 4'd0;
        n_acc  = to_mode ? TO : waits + 1;
        @(negedge pclk);
        check_eq({t, ":idle_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_wdata = wd; cmd_strb = st;
        pready = 1'b0; pslverr = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_wdata = 32'hDEAD_BEEF; cmd_strb = 4'hF; cmd_addr = '1;
        check_eq({t, ":setup_psel"}, 32'(psel), 32'd1);
        check_eq({t, ":setup_penable"}, 32'(penable), 32'd0);
        check_eq({t, ":setup_paddr"}, 32'(paddr), 32'(a));
        check_eq({t, ":setup_pwrite"}, 32'(pwrite), 32'(wr));
        check_eq({t, ":setup_pwdata"}, pwdata, exp_wd);
        check_eq({t, ":setup_pstrb"}, 32'(pstrb), 32'(exp_st));
        check_eq({t, ":setup_ready"}, 32'(cmd_ready), 32'd0);
        for (int i = 0; i < n_acc; i++) begin
            @(negedge pclk);
            check_eq({t, ":acc_psel"}, 32'(psel), 32'd1);
            check_eq({t, ":acc_penable"}, 32'(penable), 32'd1);
            check_eq({t, ":acc_paddr"}, 32'(paddr), 32'(a));
            check_eq({t, ":acc_pwdata"}, pwdata, exp_wd);
            check_eq({t, ":acc_pstrb"}, 32'(pstrb), 32'(exp_st));
            check_eq({t, ":acc_no_rsp"}, 32'(rsp_valid), 32'd0);
            if (!to_mode && i == waits) begin
                pready = 1'b1; prdata = prd; pslverr = perr;
            end else begin
                pready = 1'b0; prdata = 32'h5555_AAAA; pslverr = 1'b1;
            end
        end
        @(negedge pclk);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        check_eq({t, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({t, ":rsp_rdata"}, rsp_rdata, exp_rd);
        check_eq({t, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check_eq({t, ":rsp_timeout"}, 32'(rsp_timeout), 32'(exp_to));
        check_eq({t, ":rsp_psel"}, 32'(psel), 32'd0);
        check_eq({t, ":rsp_penable"}, 32'(penable), 32'd0);
        @(negedge pclk);
        check_eq({t, ":after_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({t, ":after_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({t, ":after_paddr_hold"}, 32'(paddr), 32'(a));
    endtask

    initial begin
        int sent;
        int got;

        @(negedge pclk);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_psel", 32'(psel), 32'd0);
        check_eq("rst_penable", 32'(penable), 32'd0);
        check_eq("rst_paddr", 32'(paddr), 32'd0);
        check_eq("rst_pwdata", pwdata, 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        preset_n = 1'b1;

        run_cmd("wr_nowait", 10'd5, 1'b1, 32'hA5A5_1234, 4'b0011, 0, 1'b0, 32'h0, 1'b0,
                32'h0, 1'b0, 1'b0);
        run_cmd("rd_3wait", 10'd7, 1'b0, 32'h1111_2222, 4'b1111, 3, 1'b0, 32'h0000_00C3, 1'b0,
                32'h0000_00C3, 1'b0, 1'b0);
        run_cmd("rd_edge15", 10'd12, 1'b0, 32'h0, 4'b0000, 15, 1'b0, 32'h0BAD_F00D, 1'b0,
                32'h0BAD_F00D, 1'b0, 1'b0);
        run_cmd("rd_timeout", 10'd3, 1'b0, 32'h0, 4'b0000, 0, 1'b1, 32'h0, 1'b0,
                32'h0, 1'b1, 1'b1);
        run_cmd("wr_after_to", 10'h3FF, 1'b1, 32'h0102_0304, 4'b1000, 1, 1'b0, 32'hFFFF_FFFF, 1'b0,
                32'h0, 1'b0, 1'b0);
        run_cmd("rd_slverr", 10'd9, 1'b0, 32'h0, 4'b0000, 0, 1'b0, 32'h0000_0077, 1'b1,
                32'h0000_0077, 1'b1, 1'b0);

        // Reset while waiting in ACCESS
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_addr = 10'd7; cmd_write = 1'b0; pready = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check_eq("mid_in_access", 32'(penable), 32'd1);
        #2 preset_n = 1'b0;
        #1;
        check_eq("mid_psel", 32'(psel), 32'd0);
        check_eq("mid_penable", 32'(penable), 32'd0);
        check_eq("mid_paddr", 32'(paddr), 32'd0);
        check_eq("mid_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("mid_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("mid_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check_eq("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        preset_n = 1'b1;
        @(negedge pclk);
        check_eq("mid_post_no_rsp", 32'(rsp_valid), 32'd0);

        // Back-to-back reads with cmd_valid held high; prdata echoes 0x100+paddr
        pready = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd1; cmd_valid = 1'b1;
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge pclk);
            prdata = 32'h100 + 32'(paddr);
            if (rsp_valid) begin
                check_eq("b2b_rdata", rsp_rdata, 32'h101 + 32'(got));
                got++;
            end
            if (psel && !penable) begin
                check_eq("b2b_addr", 32'(paddr), 32'(sent + 1));
                check_eq("b2b_busy", 32'(cmd_ready), 32'd0);
                sent++;
                if (sent < 3) cmd_addr = AW'(sent + 1);
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0; pready = 1'b0;
        check_eq("b2b_accepted", 32'(sent), 32'd3);
        check_eq("b2b_rsp_count", 32'(got), 32'd3);
        repeat (3) @(negedge pclk);
        check_eq("b2b_quiet", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB4 requester that turns single-beat commands from a local controller into APB SETUP/ACCESS transfers, waits for the completer's `pready`, and returns read data and error status on a one-cycle response strobe. It is the initiator end of the bus our register-bank bridges sit on; it drives their `psel`/`penable`/`pwrite`/`pstrb` side and samples their `pready`/`prdata`/`pslverr`. A wait-state timeout keeps a dead or unmapped completer from hanging the controller.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: width of `cmd_addr` and `paddr`.
- `TIMEOUT_CYCLES`, default 16: maximum number of ACCESS cycles with `pready` low before abort; 0 disables the timeout.

Ports (one clock, `pclk`; reset `preset_n` is asynchronous and active-low):
- `pclk` in 1: clock for all logic.
- `preset_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_addr` in `ADDR_WIDTH`: target address.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_wdata` in 32: write data.
- `cmd_strb` in 4: byte strobes for writes.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: read data; 0 for writes and aborts.
- `rsp_err` out 1: `pslverr` or timeout.
- `rsp_timeout` out 1: abort caused by timeout.
- `paddr` out `ADDR_WIDTH`: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `pwdata` out 32: APB write data.
- `pstrb` out 4: APB write strobes.
- `pready` in 1: completer ready.
- `prdata` in 32: completer read data.
- `pslverr` in 1: completer error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- `cmd_ready` = (state == IDLE), decoded from state. It is high during reset and immediately after reset.
- IDLE: on `cmd_valid && cmd_ready`, latch addr/write/wdata/strb and go to SETUP.
- SETUP (exactly 1 cycle): `psel`=1, `penable`=0, and `paddr`/`pwrite`/`pwdata`/`pstrb` are valid. Next state is ACCESS.
- ACCESS: `psel`=1, `penable`=1, and all APB outputs are held stable.
  - `pready`=1: capture `pslverr`. Capture `prdata` only on reads; the captured value is 0 on writes. Go to RESP.
  - `pready`=0: increment the wait counter.
  - Timeout: if `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES` with `pready` still low, abort. Set `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, and go to RESP.
- RESP (1 cycle): `rsp_valid`=1, `psel`=0, `penable`=0. Next state is IDLE. There is no response backpressure; the controller must sample on the strobe.
- Reads drive `pstrb`=4'b0000 and `pwdata`=0, regardless of `cmd_strb`/`cmd_wdata`.
- `paddr`/`pwrite` keep their last values when idle. `psel`=0 outside SETUP/ACCESS.
- The wait counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide, cleared on entry to SETUP, and saturates.
- `rsp_rdata`/`rsp_err`/`rsp_timeout` hold their values until the next response. They are only meaningful while `rsp_valid`=1.

## Timing
- All outputs except `cmd_ready` are registered.
- Reset values: `psel`=`penable`=`pwrite`=0, `paddr`=0, `pwdata`=0, `pstrb`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0. State is IDLE.
- Zero-wait transfer: command accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2 with `pready`=1, `rsp_valid` in cycle 3, `cmd_ready` high again in cycle 4. Minimum is 4 cycles per command.
- Each `pready`-low cycle in ACCESS adds one cycle.
- Timeout abort: `rsp_valid` is asserted the cycle after the `TIMEOUT_CYCLES`-th wait cycle.
- `pready` is ignored outside ACCESS.
- If `pready` rises in the same cycle the counter would reach the limit, the completion wins: it is a normal response, not a timeout.
- Reset mid-transfer: all outputs go to their reset values asynchronously and no response is issued for the aborted command.

## Test plan
- Write, no wait: cmd addr 5, wdata 0xA5A5_1234, strb 4'b0011. Required: SETUP then ACCESS with `pstrb`=0011, `pwdata` stable. `rsp_valid` in cycle 3 with `rsp_err`=0, `rsp_rdata`=0.
- Read, 3 wait states: cmd addr 7, `cmd_strb`=4'b1111. Required: `pstrb`=0 and `pwdata`=0 throughout. ACCESS lasts 4 cycles and APB outputs do not change. `prdata`=0x0000_00C3 produces `rsp_rdata`=0xC3.
- Completer error: read addr 9 with `pslverr`=1 alongside `pready`. Required: `rsp_err`=1, `rsp_timeout`=0.
- Timeout, `TIMEOUT_CYCLES`=16, `pready` held low: after 16 ACCESS cycles, `psel`/`penable` drop, `rsp_valid`=1 with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. The next command proceeds normally.
- Back-to-back: `cmd_valid` held high for 3 commands. Required: each accepted only when `cmd_ready`=1, and exactly 3 `rsp_valid` pulses in order.
- Reset during ACCESS (wait state): required: APB outputs and `rsp_*` go to 0 immediately, no `rsp_valid`, and `cmd_ready`=1.
